cnt_req_sched: RTL and testbench
================================

// Module: cnt_req_sched
// PURPOSE
//  Round-robin scheduler that shares one up_down_cnt instance among NUM_REQ requesters.
//  Each requester asks for a direction (up/down) and a step count. The winner drives the
//  counter's cnt_in1/cnt_in0 mode pins for exactly that many cycles, then gets a done pulse.
//  Sits directly in front of up_down_cnt; count_out is fed back for limit checks.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  STEP_W   4  width of per-request step count
//  CNT_W    4  width of the counter being driven (matches count_out)
// PORTS
//  cnt_clk    in   1               single clock, all logic on posedge
//  cnt_rst    in   1               synchronous, active-high reset
//  req_valid  in   NUM_REQ         request pending, held until accepted
//  req_dir    in   NUM_REQ         1 = count up, 0 = count down (per requester)
//  req_steps  in   NUM_REQ*STEP_W  steps for requester i at [i*STEP_W +: STEP_W]
//  req_ready  out  NUM_REQ         one-hot accept; a request transfers when valid & ready
//  req_done   out  NUM_REQ         one-cycle completion pulse to the owning requester
//  busy       out  1               high from acceptance through the DONE cycle
//  grant_id   out  $clog2(NUM_REQ) index of the current owner; valid while busy
//  clipped    out  1               high in the DONE cycle if the run ended early at a limit
//  cnt_in0    out  1               counter mode pin, bit 0
//  cnt_in1    out  1               counter mode pin, bit 1
//  count_in   in   CNT_W           up_down_cnt count_out, used for the limit check
// BEHAVIOUR
//  - Mode encoding {cnt_in1,cnt_in0}: 00 = hold, 10 = up, 01 = down, 11 = hold (never driven).
//  - Reset: state IDLE; rr pointer 0; all outputs 0 (mode = hold). Reset in RUN/DONE drops
//    the transaction with no req_done pulse.
//  - IDLE: req_ready is combinational. Search starts at the pointer and wraps upward; the
//    first index with req_valid set gets ready=1. Ready stays 0 when no request is valid.
//    On accept: latch dir, steps and id; steps!=0 -> RUN, steps==0 -> DONE.
//  - RUN: drive up or down every cycle and decrement the remaining count.
//    The last drive cycle is remaining==1, followed by DONE. Exactly `steps` drive cycles.
//  - DONE: mode = hold; req_done[id]=1 for one cycle; pointer <- id+1 (mod NUM_REQ); go to IDLE.
//  - Latency: acceptance edge to req_done = steps+1 cycles. Next accept is possible the cycle
//    after DONE. Back-to-back cost is steps+2 cycles per request.
//  - req_ready is 0 outside IDLE; requests arriving during RUN wait and are not lost.
//  - Counter wrap (no guard): requests run all steps, so up from 15 by 2 ends at 1.
//  - Simultaneous valid from all requesters: served strictly in pointer order, no starvation.
// CONFIGURATION
//  CNT_BOUND_GUARD_EN defined:
//   - In RUN, if dir=up and count_in==all-ones, or dir=down and count_in==0, mode = hold
//     that cycle and go to DONE with clipped=1. Remaining steps are discarded.
//  CNT_BOUND_GUARD_EN undefined:
//   - No limit check; count_in is unused and clipped is tied 0.
// STRUCTURE
//  - Package cnt_ctrl_pkg: state enum {IDLE, RUN, DONE}.
//  - Package cnt_ctrl_pkg: mode constants CNT_HOLD=2'b00, CNT_UP=2'b10, CNT_DOWN=2'b01.
//  - Sub-module cnt_rr_pick: combinational round-robin picker.
//    Inputs: req_valid, ptr. Outputs: one-hot grant, grant index, any_valid.
//  - Top: FSM, latched request, remaining-step counter, pointer, output decode.
// TESTING (bench instantiates up_down_cnt + cnt_req_sched)
//  1. Reset, count=0, req0 up steps=5 -> exactly 5 cycles of mode 10.
//     req_done[0] pulses at accept+6; count=5.
//  2. req_valid=4'b1111, all steps=1 -> grants in order 0,1,2,3; one done pulse each.
//     A second round, with all four still valid, starts again at 0.
//  3. Pointer at 2, req_valid=4'b0011 -> grant goes to 0 (wraps past 2,3); then 1.
//  4. req1 steps=0 -> no mode drive; req_done[1] one cycle after accept; count unchanged.
//  5. cnt_rst asserted mid-RUN of an 8-step request -> next cycle IDLE, mode 00, busy=0.
//     No req_done; re-request accepted afterwards.
//  6. Count=14, up steps=4: with CNT_BOUND_GUARD_EN -> stops at 15, clipped=1.
//     Without CNT_BOUND_GUARD_EN -> count=2, clipped=0.

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the counter request scheduler.
// Holds the scheduler state encoding and the up_down_cnt mode pin encoding.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mode pins are packed as {cnt_in1, cnt_in0}; 2'b11 is never driven.
  localparam logic [1:0] CNT_HOLD = 2'b00;
  localparam logic [1:0] CNT_UP   = 2'b10;
  localparam logic [1:0] CNT_DOWN = 2'b01;

endpackage

// File: rtl/cnt_rr_pick.sv
// Combinational round-robin picker: scans upward from ptr with wrap-around and
// reports the first valid requester as a one-hot grant plus its index.
module cnt_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_valid
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic              found;
  logic [ID_W-1:0]   idx;

  // Walk the requesters in priority order starting at ptr; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
    any_valid = |req_valid;
  end

endmodule

// File: rtl/cnt_req_sched.sv
// Round-robin scheduler sharing one up_down_cnt among NUM_REQ requesters.
// The winner drives the counter mode pins for its requested number of cycles
// and then receives a one-cycle req_done pulse.
// Optional feature macro: CNT_BOUND_GUARD_EN -- stops a run early (clipped=1)
// when the counter sits at the limit it is heading toward.
module cnt_req_sched
  import cnt_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int STEP_W  = 4,
  parameter int CNT_W   = 4
) (
  input  logic                       cnt_clk,
  input  logic                       cnt_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_dir,
  input  logic [NUM_REQ*STEP_W-1:0]  req_steps,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       clipped,
  output logic                       cnt_in0,
  output logic                       cnt_in1,
  input  logic [CNT_W-1:0]           count_in
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                clip_q, clip_d;
  logic [1:0]          mode;
  logic                limit_hit;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [STEP_W-1:0]   pick_steps;
  logic [STEP_W-1:0]   steps_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_steps
    assign steps_arr[g] = req_steps[g*STEP_W +: STEP_W];
  end

  assign pick_steps = steps_arr[pick_idx];

  cnt_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

`ifdef CNT_BOUND_GUARD_EN
  assign limit_hit = dir_q ? (count_in == '1) : (count_in == '0);
  assign clipped   = (state_q == DONE) && clip_q;
`else
  logic unused_sig;
  assign limit_hit  = 1'b0;
  assign clipped    = 1'b0;
  assign unused_sig = ^{count_in, clip_q};
`endif

  // Next-state, request latch and output decode for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    clip_d    = clip_q;
    req_ready = '0;
    req_done  = '0;
    mode      = CNT_HOLD;
    case (state_q)
      IDLE: begin
        clip_d = 1'b0;
        // Ready is masked during reset so no transfer is reported that is then lost.
        if (pick_any && !cnt_rst) begin
          req_ready = pick_oh;
          id_d      = pick_idx;
          dir_d     = req_dir[pick_idx];
          rem_d     = pick_steps;
          state_d   = (pick_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (limit_hit) begin
          clip_d  = 1'b1;
          state_d = DONE;
        end else begin
          mode  = dir_q ? CNT_UP : CNT_DOWN;
          rem_d = rem_q - 1'b1;
          if (rem_q == STEP_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!cnt_rst) req_done[id_q] = 1'b1;
        ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer and clip flag are reset.
  always_ff @(posedge cnt_clk) begin
    if (cnt_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      clip_q  <= clip_d;
    end
  end

  // Latched request fields; only meaningful while busy, so left unreset.
  always_ff @(posedge cnt_clk) begin
    id_q  <= id_d;
    dir_q <= dir_d;
    rem_q <= rem_d;
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = busy ? id_q : '0;
  assign cnt_in1  = mode[1];
  assign cnt_in0  = mode[0];

endmodule

// File: tb/tb_cnt_req_sched.sv
// Testbench for cnt_req_sched with a behavioural up/down counter in the loop.
module tb_cnt_req_sched;

  localparam int N  = 4;
  localparam int SW = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid, req_dir, req_ready, req_done;
  logic [N*SW-1:0]   req_steps;
  logic              busy, clipped, cnt_in0, cnt_in1;
  logic [IW-1:0]     grant_id;
  logic [CW-1:0]     count;
  logic              env_rst;

  cnt_req_sched #(.NUM_REQ(N), .STEP_W(SW), .CNT_W(CW)) dut (
    .cnt_clk   (clk),
    .cnt_rst   (rst),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_steps (req_steps),
    .req_ready (req_ready),
    .req_done  (req_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .clipped   (clipped),
    .cnt_in0   (cnt_in0),
    .cnt_in1   (cnt_in1),
    .count_in  (count)
  );

  // Stand-in for up_down_cnt: 10 = up, 01 = down, else hold; wraps freely.
  always @(posedge clk) begin
    if (env_rst) count <= '0;
    else if ({cnt_in1, cnt_in0} == 2'b10) count <= count + 1'b1;
    else if ({cnt_in1, cnt_in0} == 2'b01) count <= count - 1'b1;
  end

  typedef struct {
    int id;
    int end_cnt;
    int clip;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   scr[N][$];          // per-requester script: dir*16 + steps

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;
  bit rst_req  = 1;

  // Reference model: transaction-level view of the shared counter
  int m_ptr = 0, m_count = 0;
  bit m_busy = 0;
  int t_n, t_id, t_dir, t_steps, t_k, t_done, t_start, t_end;
  int acc_id = -1;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wrap16(int x);
    return ((x % 16) + 16) % 16;
  endfunction

  function automatic bit scripts_empty();
    for (int i = 0; i < N; i++) if (scr[i].size() != 0) return 0;
    return 1;
  endfunction

  // One clock cycle: update stimulus, compare against model, advance model.
  task automatic step();
    int pick, e_mode, drv, clip, room;
    @(negedge clk);
    cyc++;
    if (acc_id >= 0) begin
      req_valid[acc_id] = 1'b0;
      acc_id = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && scr[i].size() > 0) begin
        int v;
        v = scr[i].pop_front();
        req_valid[i] = 1'b1;
        req_dir[i]   = v[4];
        req_steps[i*SW +: SW] = v[3:0];
      end
    end
    rst = rst_req;
    #1;
    if (!chk_en) return;
    if (m_busy && cyc > t_done) m_busy = 0;
    pick = -1;
    if (!m_busy && !rst) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (pick < 0 && req_valid[j]) pick = j;
      end
    end
    check("req_ready", int'(req_ready), (pick >= 0) ? (1 << pick) : 0);
    e_mode = (m_busy && cyc >= t_n + 1 && cyc <= t_n + t_k) ? (t_dir ? 2 : 1) : 0;
    check("mode", int'({cnt_in1, cnt_in0}), e_mode);
    check("busy", int'(busy), int'(m_busy));
    if (m_busy) check("grant_id", int'(grant_id), t_id);
    if (rst) begin
      if (m_busy) begin
        drv = ((cyc < t_n + t_k) ? cyc : t_n + t_k) - t_n;
        if (drv < 0) drv = 0;
        m_count = wrap16(t_start + (t_dir ? drv : -drv));
        void'(sb.pop_back());
      end
      m_busy = 0;
      m_ptr  = 0;
    end else if (m_busy && cyc == t_done) begin
      m_ptr   = (t_id + 1) % N;
      m_count = t_end;
    end
    if (pick >= 0) begin
      t_n     = cyc;
      t_id    = pick;
      t_dir   = int'(req_dir[pick]);
      t_steps = int'(req_steps[pick*SW +: SW]);
      t_start = m_count;
      clip    = 0;
      t_k     = t_steps;
`ifdef CNT_BOUND_GUARD_EN
      room = t_dir ? (15 - t_start) : t_start;
      if (t_steps > room) begin
        t_k  = room;
        clip = 1;
      end
`else
      room = 0;
`endif
      t_done = cyc + t_k + 1 + clip;
      t_end  = wrap16(t_start + (t_dir ? t_k : -t_k));
      sb.push_back('{t_id, t_end, clip, t_done});
      m_busy = 1;
      acc_id = pick;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((!scripts_empty() || req_valid != 0 || m_busy || sb.size() != 0) && t < 400) begin
      step();
      t++;
    end
    check("drain_timeout", int'(t < 400), 1);
  endtask

  // Scoreboard monitor: consumes one expected completion per req_done pulse.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        check("done_missing", 0, 1);
        void'(sb.pop_front());
      end
      if (req_done != 0) begin
        if (sb.size() == 0) check("done_unexpected", int'(req_done), 0);
        else begin
          mon_e = sb.pop_front();
          check("done_id", int'(req_done), 1 << mon_e.id);
          check("done_cycle", cyc, mon_e.done_cyc);
          check("done_count", int'(count), mon_e.end_cnt);
          check("done_clipped", int'(clipped), mon_e.clip);
        end
      end else begin
        check("clipped_quiet", int'(clipped), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    req_valid = '0;
    req_dir   = '0;
    req_steps = '0;
    rst       = 1'b1;
    env_rst   = 1'b1;
    rst_req   = 1'b1;
    repeat (3) step();
    env_rst = 1'b0;
    rst_req = 1'b0;
    chk_en  = 1'b1;

    // Reset state, then req0 up 5 from count 0
    step();
    scr[0].push_back(16 + 5);
    drain();

    // Move pointer to 0, then two full rounds with everyone valid
    scr[3].push_back(0);
    drain();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) scr[i].push_back(16 + 1);
    drain();

    // Pointer at 2 with only 0 and 1 requesting
    scr[1].push_back(16 + 1);
    drain();
    scr[0].push_back(1);
    scr[1].push_back(1);
    drain();

    // Zero-step request
    scr[1].push_back(0);
    drain();

    // Reset in the middle of an 8-step run, then a fresh request
    begin
      int t = 0;
      scr[2].push_back(16 + 8);
      while (!(m_busy && cyc == t_n + 3) && t < 100) begin
        step();
        t++;
      end
      check("rst_wait", int'(t < 100), 1);
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      scr[2].push_back(16 + 2);
      drain();
    end

    // Bring count to 14, then up by 4 (clips or wraps depending on build)
    c = m_count;
    if (c < 14) scr[0].push_back(16 + (14 - c));
    else if (c == 15) scr[0].push_back(1);
    drain();
    scr[1].push_back(16 + 4);
    drain();

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      scr[$urandom_range(0, N-1)].push_back(int'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 6)) step();
    end
    drain();

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
